// File: rtl/sao_pkg.sv
// Shared SAO definitions: sequencer states, component indices and scan/drain timing.
// Both the statistics sequencer and the decision FSM import this.
package sao_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } stat_state_t;

  localparam logic [1:0] LUMA = 2'd0;
  localparam logic [1:0] CB   = 2'd1;
  localparam logic [1:0] CR   = 2'd2;

  localparam int XY_LEN       = 5;
  localparam int CNT_ST_LEN   = 10;
  localparam int CNT_WAIT_LEN = 6;

  localparam int LUMA_X_MAX   = 28;
  localparam int LUMA_Y_MAX   = 29;
  localparam int CHROMA_X_MAX = 13;
  localparam int CHROMA_Y_MAX = 14;

  localparam int LUMA_WAIT_CYCLE         = 34;
  localparam int CHROMA_WAIT_CYCLE       = 30;
  localparam int LUMA_BO_COLLECT_CYCLE   = 32;
  localparam int CHROMA_BO_COLLECT_CYCLE = 16;

  localparam int LUMA_SCAN_CYCLES   = (LUMA_X_MAX + 1) * (LUMA_Y_MAX + 1);
  localparam int CHROMA_SCAN_CYCLES = (CHROMA_X_MAX + 1) * (CHROMA_Y_MAX + 1);

  function automatic logic is_chroma(input logic [1:0] cidx);
    return cidx != LUMA;
  endfunction

endpackage

// File: rtl/sao_fsm_stat_if.sv
// Statistics-phase bus between the SAO stat sequencer (master) and its consumers
// (slave): CTB start, decision-busy back-pressure, scan coordinates and end_s.
interface sao_fsm_stat_if;
  import sao_pkg::*;

  logic                  start;
  logic                  deci_busy;
  logic [XY_LEN-1:0]     X;
  logic [XY_LEN-1:0]     Y;
  logic [1:0]            cIdx_st;
  logic [CNT_ST_LEN-1:0] cnt_st;
  logic                  isWorking_stat;
  logic                  scan_vld;
  logic                  bo_collect;
  logic                  end_s;

  modport master (
    input  start, deci_busy,
    output X, Y, cIdx_st, cnt_st, isWorking_stat, scan_vld, bo_collect, end_s
  );

  modport slave (
    output start, deci_busy,
    input  X, Y, cIdx_st, cnt_st, isWorking_stat, scan_vld, bo_collect, end_s
  );

endinterface

// File: rtl/sao_xy_scan.sv
// Raster X/Y counter with per-component extents; last flags the final sample
// position of the current component.
module sao_xy_scan #(
  parameter int XY_W         = 5,
  parameter int x_max_luma   = 28,
  parameter int y_max_luma   = 29,
  parameter int x_max_chroma = 13,
  parameter int y_max_chroma = 14
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            clr,
  input  logic            step,
  input  logic            chroma,
  output logic [XY_W-1:0] x,
  output logic [XY_W-1:0] y,
  output logic            last
);

  localparam logic [XY_W-1:0] XL = XY_W'(x_max_luma);
  localparam logic [XY_W-1:0] YL = XY_W'(y_max_luma);
  localparam logic [XY_W-1:0] XC = XY_W'(x_max_chroma);
  localparam logic [XY_W-1:0] YC = XY_W'(y_max_chroma);

  logic [XY_W-1:0] x_reg, y_reg;
  logic [XY_W-1:0] x_max, y_max;

  assign x_max = chroma ? XC : XL;
  assign y_max = chroma ? YC : YL;
  assign last  = (x_reg == x_max) && (y_reg == y_max);
  assign x     = x_reg;
  assign y     = y_reg;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (clr) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (step) begin
      if (x_reg == x_max) begin
        x_reg <= '0;
        y_reg <= y_reg + XY_W'(1);
      end else begin
        x_reg <= x_reg + XY_W'(1);
      end
    end
  end

endmodule

// File: rtl/sao_fsm_stat.sv
// SAO statistics-phase sequencer: walks luma, Cb, Cr scan+drain per CTB and
// hands off to the decision FSM with a single end_s pulse.
module sao_fsm_stat
  import sao_pkg::*;
#(
  parameter int luma_x_max              = LUMA_X_MAX,
  parameter int luma_y_max              = LUMA_Y_MAX,
  parameter int chroma_x_max            = CHROMA_X_MAX,
  parameter int chroma_y_max            = CHROMA_Y_MAX,
  parameter int luma_wait_cycle         = LUMA_WAIT_CYCLE,
  parameter int chroma_wait_cycle       = CHROMA_WAIT_CYCLE,
  parameter int luma_BO_collect_cycle   = LUMA_BO_COLLECT_CYCLE,
  parameter int chroma_BO_collect_cycle = CHROMA_BO_COLLECT_CYCLE
) (
  input  logic           clk,
  input  logic           arst_n,
  input  logic           rst_n,
  input  logic           en_i,
  input  logic           en_o,
  sao_fsm_stat_if.master bus
);

  localparam logic [CNT_WAIT_LEN-1:0] LUMA_WAIT_LAST   = CNT_WAIT_LEN'(luma_wait_cycle - 1);
  localparam logic [CNT_WAIT_LEN-1:0] CHROMA_WAIT_LAST = CNT_WAIT_LEN'(chroma_wait_cycle - 1);
  localparam logic [CNT_WAIT_LEN-1:0] LUMA_BO_START    =
    CNT_WAIT_LEN'(luma_wait_cycle - luma_BO_collect_cycle);
  localparam logic [CNT_WAIT_LEN-1:0] CHROMA_BO_START  =
    CNT_WAIT_LEN'(chroma_wait_cycle - chroma_BO_collect_cycle);

  stat_state_t             state_reg, state_next;
  logic [1:0]              cidx_reg, cidx_next;
  logic [CNT_ST_LEN-1:0]   cnt_st_reg, cnt_st_next;
  logic [CNT_WAIT_LEN-1:0] cnt_wait_reg, cnt_wait_next;
  logic                    bo_reg, bo_next;
  logic                    end_s_reg, end_s_next;
  logic                    working_reg, working_next;
  logic                    scan_vld_reg, scan_vld_next;

  logic                    xy_clr, xy_step, xy_last, chroma_sel;
  logic [XY_LEN-1:0]       x_cur, y_cur;
  logic [CNT_WAIT_LEN-1:0] wait_last, bo_start;

  assign chroma_sel = is_chroma(cidx_reg);
  assign wait_last  = chroma_sel ? CHROMA_WAIT_LAST : LUMA_WAIT_LAST;
  assign bo_start   = chroma_sel ? CHROMA_BO_START : LUMA_BO_START;

  sao_xy_scan #(
    .XY_W        (XY_LEN),
    .x_max_luma  (luma_x_max),
    .y_max_luma  (luma_y_max),
    .x_max_chroma(chroma_x_max),
    .y_max_chroma(chroma_y_max)
  ) u_xy_scan (
    .clk   (clk),
    .arst_n(arst_n),
    .clr   (xy_clr),
    .step  (xy_step),
    .chroma(chroma_sel),
    .x     (x_cur),
    .y     (y_cur),
    .last  (xy_last)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg    <= IDLE;
      cidx_reg     <= LUMA;
      cnt_st_reg   <= '0;
      cnt_wait_reg <= '0;
      bo_reg       <= 1'b0;
      end_s_reg    <= 1'b0;
      working_reg  <= 1'b0;
      scan_vld_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cidx_reg     <= cidx_next;
      cnt_st_reg   <= cnt_st_next;
      cnt_wait_reg <= cnt_wait_next;
      bo_reg       <= bo_next;
      end_s_reg    <= end_s_next;
      working_reg  <= working_next;
      scan_vld_reg <= scan_vld_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cidx_next     = cidx_reg;
    cnt_st_next   = cnt_st_reg;
    cnt_wait_next = cnt_wait_reg;
    bo_next       = bo_reg;
    end_s_next    = end_s_reg;
    working_next  = working_reg;
    scan_vld_next = scan_vld_reg;
    xy_clr        = 1'b0;
    xy_step       = 1'b0;

    if (!rst_n || (en_o && !en_i)) begin
      // Clear and abort both drop the CTB in progress without an end_s.
      state_next    = IDLE;
      cidx_next     = LUMA;
      cnt_st_next   = '0;
      cnt_wait_next = '0;
      bo_next       = 1'b0;
      end_s_next    = 1'b0;
      working_next  = 1'b0;
      scan_vld_next = 1'b0;
      xy_clr        = 1'b1;
    end else if (en_o) begin
      end_s_next = 1'b0;
      bo_next    = 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (bus.start) begin
            state_next  = SCAN;
            cidx_next   = LUMA;
            cnt_st_next = '0;
            xy_clr      = 1'b1;
          end
        end
        SCAN: begin
          cnt_st_next = cnt_st_reg + CNT_ST_LEN'(1);
          if (xy_last) begin
            state_next    = WAIT;
            cnt_wait_next = '0;
            bo_next       = (bo_start == '0);
          end else begin
            xy_step = 1'b1;
          end
        end
        WAIT: begin
          if (cnt_wait_reg == wait_last) begin
            cnt_wait_next = '0;
            if (cidx_reg < CR) begin
              state_next  = SCAN;
              cidx_next   = cidx_reg + 2'd1;
              cnt_st_next = '0;
              xy_clr      = 1'b1;
            end else if (!bus.deci_busy) begin
              state_next  = IDLE;
              end_s_next  = 1'b1;
              cidx_next   = LUMA;
              cnt_st_next = '0;
              xy_clr      = 1'b1;
            end else begin
              state_next = HOLD;
            end
          end else begin
            cnt_wait_next = cnt_wait_reg + CNT_WAIT_LEN'(1);
            cnt_st_next   = cnt_st_reg + CNT_ST_LEN'(1);
            bo_next       = (cnt_wait_reg + CNT_WAIT_LEN'(1)) >= bo_start;
          end
        end
        HOLD: begin
          if (!bus.deci_busy) begin
            state_next  = IDLE;
            end_s_next  = 1'b1;
            cidx_next   = LUMA;
            cnt_st_next = '0;
            xy_clr      = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
      working_next  = (state_next != IDLE);
      scan_vld_next = (state_next == SCAN);
    end
  end

  assign bus.X              = x_cur;
  assign bus.Y              = y_cur;
  assign bus.cIdx_st        = cidx_reg;
  assign bus.cnt_st         = cnt_st_reg;
  assign bus.isWorking_stat = working_reg;
  assign bus.scan_vld       = scan_vld_reg;
  assign bus.bo_collect     = bo_reg;
  assign bus.end_s          = end_s_reg;

endmodule
